// File: rtl/pe_dispatcher.sv
// pe_dispatcher: job-level initiator for one PE.
// Accepts a job descriptor and derives the PE iteration counts. It then pulses
// start, waits for the PE finish level under a watchdog, captures the 3*CH
// feature vector and drains it as an indexed valid/ready stream.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a job descriptor
// S_START | one-cycle start pulse to the PE, wait counter cleared
// S_WAIT  | waiting for PE finish (first cycle ignores a stale level)
// S_DRAIN | streaming captured features, one element per accepted beat
module pe_dispatcher #(
  parameter int CH      = 32,
  parameter int WC      = 64,
  parameter int DW      = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_job_valid,
  output logic                        o_job_ready,
  input  logic [$clog2(CH):0]         i_job_ia_len,
  input  logic [$clog2(WC):0]         i_job_w_len,
  output logic                        o_pe_start,
  output logic [$clog2(CH):0]         o_pe_ia_len,
  output logic [$clog2(CH):0]         o_pe_ia_iters,
  output logic [$clog2(WC):0]         o_pe_w_len,
  output logic [$clog2(WC):0]         o_pe_w_iters,
  input  logic                        i_pe_finish,
  input  logic [3*CH*DW-1:0]          i_pe_feature,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [DW-1:0]               o_out_data,
  output logic [$clog2(3*CH)-1:0]     o_out_idx,
  output logic                        o_out_last,
  output logic                        o_busy,
  output logic                        o_error,
  output logic [15:0]                 o_jobs_done
);

  localparam int NE     = 3 * CH;
  localparam int IAW    = $clog2(CH) + 1;
  localparam int WW     = $clog2(WC) + 1;
  localparam int IXW    = $clog2(NE);
  localparam int CW     = $clog2(TIMEOUT);
  // PE iterations are counted in blocks of 32 entries
  localparam int DIV    = 32;
  localparam int DIV_SH = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e               state_q;
  logic                 job_ready_q;
  logic                 pe_start_q;
  logic [IAW-1:0]       ia_len_q;
  logic [IAW-1:0]       ia_iters_q;
  logic [WW-1:0]        w_len_q;
  logic [WW-1:0]        w_iters_q;
  logic [CW-1:0]        wait_cnt_q;
  logic                 first_wait_q;
  logic [NE*DW-1:0]     feat_q;
  logic                 out_valid_q;
  logic [DW-1:0]        out_data_q;
  logic [IXW-1:0]       out_idx_q;
  logic                 out_last_q;
  logic                 busy_q;
  logic                 error_q;
  logic [15:0]          jobs_done_q;

  logic [IAW:0]         ia_ceil;
  logic [WW:0]          w_ceil;
  logic [IAW-1:0]       ia_iters_d;
  logic [WW-1:0]        w_iters_d;
  logic [IXW-1:0]       idx_nxt;

  // iteration counts: ia is ceil(len/32)-1 floored at 0, w is ceil(len/32)
  always_comb begin
    ia_ceil    = ({1'b0, i_job_ia_len} + (IAW+1)'(DIV - 1)) >> DIV_SH;
    w_ceil     = ({1'b0, i_job_w_len} + (WW+1)'(DIV - 1)) >> DIV_SH;
    ia_iters_d = (ia_ceil == '0) ? '0 : IAW'(ia_ceil - 1'b1);
    w_iters_d  = WW'(w_ceil);
    idx_nxt    = out_idx_q + 1'b1;
  end

  // job FSM with all outputs registered
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      job_ready_q  <= 1'b0;
      pe_start_q   <= 1'b0;
      ia_len_q     <= '0;
      ia_iters_q   <= '0;
      w_len_q      <= '0;
      w_iters_q    <= '0;
      wait_cnt_q   <= '0;
      first_wait_q <= 1'b0;
      feat_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
      jobs_done_q  <= '0;
    end else begin
      pe_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // ready is registered, so a job is only taken once ready is visible
          if (i_job_valid && job_ready_q) begin
            ia_len_q    <= i_job_ia_len;
            ia_iters_q  <= ia_iters_d;
            w_len_q     <= i_job_w_len;
            w_iters_q   <= w_iters_d;
            error_q     <= 1'b0;
            pe_start_q  <= 1'b1;
            job_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_START;
          end else begin
            job_ready_q <= 1'b1;
          end
        end
        S_START: begin
          wait_cnt_q   <= '0;
          first_wait_q <= 1'b1;
          state_q      <= S_WAIT;
        end
        S_WAIT: begin
          first_wait_q <= 1'b0;
          // finish beats a same-cycle timeout
          if (i_pe_finish && !first_wait_q) begin
            feat_q      <= i_pe_feature;
            out_idx_q   <= '0;
            out_data_q  <= i_pe_feature[DW-1:0];
            out_valid_q <= 1'b1;
            out_last_q  <= (NE == 1);
            state_q     <= S_DRAIN;
          end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
            error_q     <= 1'b1;
            busy_q      <= 1'b0;
            job_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (i_out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              jobs_done_q <= jobs_done_q + 1'b1;
              busy_q      <= 1'b0;
              job_ready_q <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              out_idx_q  <= idx_nxt;
              out_data_q <= feat_q[int'(idx_nxt)*DW +: DW];
              out_last_q <= (idx_nxt == IXW'(NE - 1));
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_job_ready   = job_ready_q;
  assign o_pe_start    = pe_start_q;
  assign o_pe_ia_len   = ia_len_q;
  assign o_pe_ia_iters = ia_iters_q;
  assign o_pe_w_len    = w_len_q;
  assign o_pe_w_iters  = w_iters_q;
  assign o_out_valid   = out_valid_q;
  assign o_out_data    = out_data_q;
  assign o_out_idx     = out_idx_q;
  assign o_out_last    = out_last_q;
  assign o_busy        = busy_q;
  assign o_error       = error_q;
  assign o_jobs_done   = jobs_done_q;

endmodule

// File: tb/tb_pe_dispatcher.sv
// Directed bench for pe_dispatcher with hand-computed expectations.
module tb_pe_dispatcher;

  localparam int CH = 32;
  localparam int WC = 64;
  localparam int DW = 16;
  localparam int NE = 3 * CH;

  logic                    i_clk = 1'b0;
  logic                    i_rst;
  logic                    i_job_valid;
  logic                    o_job_ready;
  logic [5:0]              i_job_ia_len;
  logic [6:0]              i_job_w_len;
  logic                    o_pe_start;
  logic [5:0]              o_pe_ia_len;
  logic [5:0]              o_pe_ia_iters;
  logic [6:0]              o_pe_w_len;
  logic [6:0]              o_pe_w_iters;
  logic                    i_pe_finish;
  logic [NE*DW-1:0]        i_pe_feature;
  logic                    o_out_valid;
  logic                    i_out_ready;
  logic [DW-1:0]           o_out_data;
  logic [6:0]              o_out_idx;
  logic                    o_out_last;
  logic                    o_busy;
  logic                    o_error;
  logic [15:0]             o_jobs_done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  pe_dispatcher #(.CH(CH), .WC(WC), .DW(DW), .TIMEOUT(16)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_job_valid   (i_job_valid),
    .o_job_ready   (o_job_ready),
    .i_job_ia_len  (i_job_ia_len),
    .i_job_w_len   (i_job_w_len),
    .o_pe_start    (o_pe_start),
    .o_pe_ia_len   (o_pe_ia_len),
    .o_pe_ia_iters (o_pe_ia_iters),
    .o_pe_w_len    (o_pe_w_len),
    .o_pe_w_iters  (o_pe_w_iters),
    .i_pe_finish   (i_pe_finish),
    .i_pe_feature  (i_pe_feature),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_out_data    (o_out_data),
    .o_out_idx     (o_out_idx),
    .o_out_last    (o_out_last),
    .o_busy        (o_busy),
    .o_error       (o_error),
    .o_jobs_done   (o_jobs_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic fill(input logic [15:0] base);
    for (int k = 0; k < NE; k++)
      i_pe_feature[k*DW +: DW] = base + 16'(k);
  endtask

  // presents a job and returns the accept cycle; leaves us in the start cycle
  task automatic accept(input logic [5:0] ia, input logic [6:0] w, output int t);
    i_job_valid  = 1'b1;
    i_job_ia_len = ia;
    i_job_w_len  = w;
    for (int k = 0; k < 20 && !o_job_ready; k++) tick();
    check("job_ready", o_job_ready, 1);
    t = cyc;
    tick();
    i_job_valid = 1'b0;
    check("pe_start", o_pe_start, 1);
    check("busy_start", o_busy, 1);
    check("ready_low", o_job_ready, 0);
    check("error_clr", o_error, 0);
    check("ia_len", o_pe_ia_len, ia);
    check("w_len", o_pe_w_len, w);
  endtask

  // collects one full drain; finish must already be driven in this cycle
  task automatic drain(input logic [15:0] base, input bit bp, output int last_c);
    int cnt = 0;
    bit stalled = 0;
    bit done = 0;
    logic [6:0]  p_idx = '0;
    logic [15:0] p_dat = '0;
    bit rdy;
    last_c = -1;
    tick();
    check("first_beat", o_out_valid, 1);
    for (int c = 0; c < 400 && !done; c++) begin
      if (stalled) begin
        check("hold_idx", o_out_idx, p_idx);
        check("hold_data", o_out_data, p_dat);
      end
      rdy = bp ? (c % 2 == 0) : 1'b1;
      i_out_ready = rdy;
      stalled = 0;
      if (o_out_valid) begin
        if (rdy) begin
          check("beat_idx", o_out_idx, cnt);
          check("beat_data", o_out_data, base + 16'(cnt));
          check("beat_last", o_out_last, (cnt == NE - 1));
          if (o_out_last) begin
            done = 1;
            last_c = cyc;
          end
          cnt++;
        end else begin
          stalled = 1;
          p_idx = o_out_idx;
          p_dat = o_out_data;
        end
      end
      tick();
    end
    i_out_ready = 1'b1;
    check("beat_count", cnt, NE);
    check("post_valid", o_out_valid, 0);
    check("post_ready", o_job_ready, 1);
    check("post_busy", o_busy, 0);
  endtask

  task automatic run_job(input logic [5:0] ia, input logic [6:0] w,
                         input logic [5:0] e_ia_it, input logic [6:0] e_w_it,
                         input int nfin, input logic [15:0] base, input bit bp,
                         output int lat);
    int t;
    int starts;
    int last_c;
    accept(ia, w, t);
    check("ia_iters", o_pe_ia_iters, e_ia_it);
    check("w_iters", o_pe_w_iters, e_w_it);
    starts = 1;
    tick();
    starts += int'(o_pe_start);
    tick();
    starts += int'(o_pe_start);
    // a finish level left over from the previous job must not be captured
    i_pe_finish = 1'b0;
    check("no_stale_capture", o_out_valid, 0);
    check("wait_busy", o_busy, 1);
    for (int i = 2; i < nfin; i++) begin
      tick();
      starts += int'(o_pe_start);
      check("wait_no_valid", o_out_valid, 0);
    end
    fill(base);
    i_pe_finish = 1'b1;
    check("start_pulses", starts, 1);
    drain(base, bp, last_c);
    lat = last_c - t;
  endtask

  initial begin
    int lat;
    int t;
    i_rst        = 1'b1;
    i_job_valid  = 1'b0;
    i_job_ia_len = '0;
    i_job_w_len  = '0;
    i_pe_finish  = 1'b0;
    i_pe_feature = '0;
    i_out_ready  = 1'b1;
    tick();
    tick();
    check("rst_ready", o_job_ready, 0);
    check("rst_busy", o_busy, 0);
    check("rst_start", o_pe_start, 0);
    check("rst_valid", o_out_valid, 0);
    check("rst_error", o_error, 0);
    check("rst_jobs", o_jobs_done, 0);
    check("rst_idx", o_out_idx, 0);
    check("rst_data", o_out_data, 0);
    check("rst_ia_len", o_pe_ia_len, 0);
    i_rst = 1'b0;
    tick();
    check("ready_after_rst", o_job_ready, 1);

    // basic job, finish 10 cycles after start
    run_job(6'd32, 7'd64, 6'd0, 7'd2, 10, 16'h0000, 1'b0, lat);
    check("jobs_after_a", o_jobs_done, 1);
    check("ia_len_hold", o_pe_ia_len, 32);

    // finish stays high from the previous job through the first WAIT cycle
    run_job(6'd1, 7'd32, 6'd0, 7'd1, 5, 16'h8000, 1'b0, lat);
    check("jobs_after_b", o_jobs_done, 2);

    // backpressure with ready toggling
    run_job(6'd63, 7'd127, 6'd1, 7'd4, 2, 16'h1234, 1'b1, lat);
    check("jobs_after_c", o_jobs_done, 3);

    // zero lengths, minimum latency
    run_job(6'd0, 7'd0, 6'd0, 7'd0, 2, 16'h0F00, 1'b0, lat);
    check("min_latency", lat, 3 * CH + 3);
    check("jobs_after_d", o_jobs_done, 4);

    // timeout: finish never arrives
    i_pe_finish = 1'b0;
    accept(6'd0, 7'd1, t);
    check("to_ia_iters", o_pe_ia_iters, 0);
    check("to_w_iters", o_pe_w_iters, 1);
    for (int i = 0; i < 16; i++) tick();
    check("to_err_before", o_error, 0);
    check("to_busy_before", o_busy, 1);
    tick();
    check("to_error", o_error, 1);
    check("to_busy", o_busy, 0);
    check("to_ready", o_job_ready, 1);
    check("to_valid", o_out_valid, 0);
    check("to_jobs", o_jobs_done, 4);
    tick();
    tick();
    check("to_err_sticky", o_error, 1);
    check("to_no_beats", o_out_valid, 0);

    // the next accept clears the error
    run_job(6'd33, 7'd64, 6'd1, 7'd2, 3, 16'hABC0, 1'b0, lat);
    check("jobs_after_f", o_jobs_done, 5);

    // reset in the middle of a drain
    accept(6'd32, 7'd64, t);
    tick();
    tick();
    fill(16'h0500);
    i_pe_finish = 1'b1;
    i_out_ready = 1'b1;
    for (int i = 0; i < 200 && !(o_out_valid && o_out_idx == 7'd40); i++) tick();
    check("reach_idx40", o_out_idx, 40);
    check("data_idx40", o_out_data, 16'h0500 + 16'd40);
    i_rst = 1'b1;
    tick();
    check("mr_ready", o_job_ready, 0);
    check("mr_valid", o_out_valid, 0);
    check("mr_last", o_out_last, 0);
    check("mr_idx", o_out_idx, 0);
    check("mr_data", o_out_data, 0);
    check("mr_busy", o_busy, 0);
    check("mr_start", o_pe_start, 0);
    check("mr_jobs", o_jobs_done, 0);
    check("mr_w_iters", o_pe_w_iters, 0);
    i_rst = 1'b0;
    tick();
    check("mr_ready_after", o_job_ready, 1);
    check("mr_valid_after", o_out_valid, 0);
    tick();
    tick();
    check("mr_no_beats", o_out_valid, 0);
    check("mr_idle", o_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

endmodule
